pio_in_irq_capture: RTL
=======================

Name: pio_in_irq_capture

Overview:
- Parametrised general-purpose input port with an Avalon-MM slave interface.
- Successor to the single-bit polled input (e.g. the "printing" status line): N-bit width, multi-stage input synchroniser, per-bit edge capture, interrupt mask and a level IRQ to the processor.
- Sits between off-chip/fabric status signals (robot sensors, game-state flags) and the Nios II system interconnect.

Parameters:
- DATA_WIDTH, 8, number of input bits (1..32).
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (2..4).
- EDGE_TYPE, 0, edge captured: 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 1024, stable cycles required before an input change is accepted (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register word address.
- chipselect  in  1  slave select, qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  DATA_WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset_n is asynchronous assert, active low. Its deassertion is assumed synchronised upstream.
  - All flops reset to 0: synchroniser chain, stable value, previous value, irq_mask, edge_capture, readdata.
  - irq = 0 in reset.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_in. Input-to-sync_in latency = SYNC_STAGES cycles.
- Data value (data_val):
  - Equals sync_in when the optional feature is off.
  - Equals the debounced value when it is on.
  - prev_val is data_val delayed one cycle.
- Edge detect, per bit i:
  - rising: data_val[i] & ~prev_val[i]
  - falling: ~data_val[i] & prev_val[i]
  - any: XOR of the two
- Register map (word addresses). Unused upper bits read as 0.
  - 0: DATA. Read-only; writes ignored.
  - 1: reserved. Reads 0; writes ignored.
  - 2: IRQ_MASK. Read/write, bits [DATA_WIDTH-1:0].
  - 3: EDGE_CAPTURE. Read; write-1-to-clear per bit.
- Write rule: a write occurs when chipselect = 1 and write_n = 0. writedata bits above DATA_WIDTH are ignored.
- Read:
  - readdata is updated every cycle from the address mux, independent of chipselect.
  - Read latency is 1 cycle: the value sampled at edge k appears after edge k.
- Edge capture, per bit:
  - A detected edge sets the bit on the next clock.
  - A write of 1 to address 3 clears the bit.
  - Same cycle set and clear: set wins, so no edge is lost.
  - The bit stays set until it is explicitly cleared. Further edges have no additional effect.
- IRQ:
  - irq = OR over i of (edge_capture[i] & irq_mask[i]), registered, one cycle after either term changes.
  - Masking a pending bit deasserts irq one cycle later. edge_capture is unaffected.
- Reset mid-operation: all state is cleared immediately and pending edges are lost. After release, no spurious edge is detected, because prev_val and data_val both start at 0.
- Synchroniser fill: a bit held high through reset produces one rising edge once it propagates. This is intended and documented for software.

Optional Feature:
- Macro: PIO_IN_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - The counter resets to 0 whenever sync_in[i] differs from the bit's current stable value and its last sample.
  - The counter increments while sync_in[i] stays at the new value.
  - On reaching DEBOUNCE_CYCLES, the stable value takes the new value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach DATA or edge detection.
  - Added latency = DEBOUNCE_CYCLES + 1 cycles.
- Undefined: no counters are instantiated, and data_val = sync_in.

Test Plan:
- Reset and DATA read:
  - Stimulus: reset_n = 0 with in_port = 8'hFF, then release and wait 4 cycles. Read address 0.
  - Response: readdata = 32'h000000FF. irq = 0 throughout, since the mask is 0.
- Rising capture and IRQ:
  - Stimulus: EDGE_TYPE = 0. Write mask 8'h01. Drive in_port[0] 0→1.
  - Response: edge_capture = 8'h01 by cycle SYNC_STAGES+1 after the input change, then irq = 1 the cycle after.
  - Stimulus: write 8'h01 to address 3.
  - Response: irq = 0 within 2 cycles.
- Set/clear collision:
  - Stimulus: write 8'h04 to address 3 in the same cycle that bit 2 sees a new edge.
  - Response: edge_capture[2] remains 1.
- Masking:
  - Stimulus: bit 3 captured with mask 8'h00.
  - Response: irq stays 0 and edge_capture reads 8'h08.
  - Stimulus: write mask 8'h08.
  - Response: irq = 1 one cycle after the mask write.
- Any-edge and width:
  - Stimulus: DATA_WIDTH = 32, EDGE_TYPE = 2. Toggle in_port[31] 0→1→0 and clear the capture between the toggles.
  - Response: each toggle sets bit 31. Write of 32'h8000_0000 to address 2 reads back exactly.
- Debounce (macro on, DEBOUNCE_CYCLES = 16):
  - Stimulus: 10-cycle pulse on bit 1.
  - Response: no DATA change and no capture.
  - Stimulus: 20-cycle pulse on bit 1.
  - Response: DATA[1] = 1 after 16 + SYNC_STAGES + 1 cycles, and capture is set.

Source files
------------

// File: rtl/pio_in_irq_capture.sv
// Avalon-MM general-purpose input port: synchroniser, per-bit edge capture, IRQ mask, level IRQ.
// Define PIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter between synchroniser and edge detect.
module pio_in_irq_capture #(
   parameter int DATA_WIDTH      = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 0,
   parameter int DEBOUNCE_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] sync_in;
   logic [DATA_WIDTH-1:0] data_val;
   logic [DATA_WIDTH-1:0] prev_q;
   logic [DATA_WIDTH-1:0] edge_det;
   logic [DATA_WIDTH-1:0] clear_bits;
   logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [DATA_WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [31:0]           readdata_q, readdata_d;
   logic                  irq_q, irq_d;
   logic                  wr_en;
   logic                  unused_wdata;

   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0]      cnt_q [DATA_WIDTH];
   logic [CNT_W-1:0]      cnt_d [DATA_WIDTH];
   logic [DATA_WIDTH-1:0] stable_q, stable_d;

   // A bit must disagree with its stable value for DEBOUNCE_CYCLES+1 consecutive cycles to flip.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync_in[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) stable_d[i] = sync_in[i];
            else                     cnt_d[i]    = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= '0;
         for (int i = 0; i < DATA_WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         stable_q <= stable_d;
         for (int i = 0; i < DATA_WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign data_val = stable_q;
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   assign data_val = sync_in;
`endif

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign edge_det = data_val & ~prev_q;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign edge_det = ~data_val & prev_q;
      end else begin : g_any
         assign edge_det = data_val ^ prev_q;
      end
   endgenerate

   assign wr_en = chipselect & ~write_n;

   // Set has priority over write-1-to-clear so an edge landing on a clear is never lost.
   always_comb begin
      irq_mask_d = irq_mask_q;
      clear_bits = '0;
      if (wr_en && (address == ADDR_MASK)) irq_mask_d = writedata[DATA_WIDTH-1:0];
      if (wr_en && (address == ADDR_EDGE)) clear_bits = writedata[DATA_WIDTH-1:0];
      edge_capture_d = (edge_capture_q & ~clear_bits) | edge_det;
      irq_d          = |(edge_capture_q & irq_mask_q);
      readdata_d     = '0;
      case (address)
         ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = data_val;
         ADDR_MASK: readdata_d[DATA_WIDTH-1:0] = irq_mask_q;
         ADDR_EDGE: readdata_d[DATA_WIDTH-1:0] = edge_capture_q;
         default:   readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q         <= '0;
         irq_mask_q     <= '0;
         edge_capture_q <= '0;
         readdata_q     <= '0;
         irq_q          <= 1'b0;
      end else begin
         prev_q         <= data_val;
         irq_mask_q     <= irq_mask_d;
         edge_capture_q <= edge_capture_d;
         readdata_q     <= readdata_d;
         irq_q          <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
